// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin read arbiter merging two source FIFOs into one stream
//
// Purpose: pops two registered-output source FIFOs (d0, d1) alternately or singly,
// never popping the same source on consecutive cycles, and presents the popped
// word two cycles later on data_out with valid_out and src_id.
//
// Optional feature macro: FIFO_RD_STATS_EN (adds saturating per-source pop counters).
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - asynchronous active-high reset
//   fifo_empty_d0  - empty flag of source d0
//   fifo_empty_d1  - empty flag of source d1
//   data_in_d0     - d0 pop data, valid the cycle after pop_d0
//   data_in_d1     - d1 pop data, valid the cycle after pop_d1
//   down_pause     - downstream almost-full; blocks new pops
//   pop_d0/pop_d1  - pop strobes, straight from state register bits
//   data_out       - merged output data, holds while valid_out is low
//   valid_out      - data_out valid this cycle
//   src_id         - source of data_out (0 = d0, 1 = d1)
//   rd_error       - one-cycle pulse: pop issued against an empty source
//   pop_cnt_d0/d1  - (FIFO_RD_STATS_EN only) issued pops, saturating at 255

module fifo_rd_arbiter #(
  parameter int DATA_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_d0,
  input  logic                 fifo_empty_d1,
  input  logic [DATA_SIZE-1:0] data_in_d0,
  input  logic [DATA_SIZE-1:0] data_in_d1,
  input  logic                 down_pause,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 src_id,
  output logic                 rd_error
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [7:0]           pop_cnt_d0,
  output logic [7:0]           pop_cnt_d1
`endif
);

  // One-hot style encoding so each pop strobe is a bare flop output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP0 = 2'b01,
    POP1 = 2'b10
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;   // 0: d0 granted most recently, 1: d1
  logic   started;      // holds off pops for the first edge after reset release
  logic   s1_valid;     // a pop happened last cycle; its data is on data_in now
  logic   s1_src;
  logic   elig0;
  logic   elig1;

  assign pop_d0 = state[0];
  assign pop_d1 = state[1];

  // Excluding the source currently being popped guarantees at most one pop per
  // two cycles per source, which hides the one-cycle lag of its empty flag.
  always_comb begin
    state_next = IDLE;
    elig0      = !fifo_empty_d0 && (state != POP0);
    elig1      = !fifo_empty_d1 && (state != POP1);
    if (!started || down_pause) begin
      state_next = IDLE;
    end else if (elig0 && elig1) begin
      state_next = last_grant ? POP0 : POP1;
    end else if (elig0) begin
      state_next = POP0;
    end else if (elig1) begin
      state_next = POP1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      started    <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      if (state_next == POP0) begin
        last_grant <= 1'b0;
      end else if (state_next == POP1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Output pipeline: pop in N, source data on data_in in N+1, registered out in N+2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_src    <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      src_id    <= 1'b0;
      rd_error  <= 1'b0;
    end else begin
      s1_valid  <= pop_d0 | pop_d1;
      s1_src    <= pop_d1;
      valid_out <= s1_valid;
      if (s1_valid) begin
        data_out <= s1_src ? data_in_d1 : data_in_d0;
        src_id   <= s1_src;
      end
      rd_error <= (pop_d0 && fifo_empty_d0) || (pop_d1 && fifo_empty_d1);
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_cnt_d0 <= 8'd0;
      pop_cnt_d1 <= 8'd0;
    end else begin
      if (pop_d0 && (pop_cnt_d0 != 8'hFF)) begin
        pop_cnt_d0 <= pop_cnt_d0 + 8'd1;
      end
      if (pop_d1 && (pop_cnt_d1 != 8'hFF)) begin
        pop_cnt_d1 <= pop_cnt_d1 + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - directed self-checking bench for fifo_rd_arbiter

module tb_fifo_rd_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       down_pause;
  logic       inj0;
  logic       fifo_empty_d0;
  logic       fifo_empty_d1;
  logic [5:0] data_in_d0 = 6'd0;
  logic [5:0] data_in_d1 = 6'd0;
  logic       pop_d0;
  logic       pop_d1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       src_id;
  logic       rd_error;
`ifdef FIFO_RD_STATS_EN
  logic [7:0] pop_cnt_d0;
  logic [7:0] pop_cnt_d1;
`endif

  int tests = 0;
  int fails = 0;

  // Source FIFO models: registered pop data, empty flag from pointers.
  logic [5:0] mem0 [0:255];
  logic [5:0] mem1 [0:255];
  int wr0 = 0;
  int wr1 = 0;
  int rd0 = 0;
  int rd1 = 0;

  assign fifo_empty_d0 = (rd0 == wr0) | inj0;
  assign fifo_empty_d1 = (rd1 == wr1);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pop_d0 && (rd0 != wr0)) begin
      data_in_d0 <= mem0[rd0[7:0]];
      rd0        <= rd0 + 1;
    end
    if (pop_d1 && (rd1 != wr1)) begin
      data_in_d1 <= mem1[rd1[7:0]];
      rd1        <= rd1 + 1;
    end
  end

  fifo_rd_arbiter #(.DATA_SIZE(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_d0(fifo_empty_d0),
    .fifo_empty_d1(fifo_empty_d1),
    .data_in_d0   (data_in_d0),
    .data_in_d1   (data_in_d1),
    .down_pause   (down_pause),
    .pop_d0       (pop_d0),
    .pop_d1       (pop_d1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .src_id       (src_id),
    .rd_error     (rd_error)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_cnt_d0   (pop_cnt_d0),
    .pop_cnt_d1   (pop_cnt_d1)
`endif
  );

  task automatic push0(input logic [5:0] v);
    mem0[wr0[7:0]] = v;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [5:0] v);
    mem1[wr1[7:0]] = v;
    wr1 = wr1 + 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/pop_d0"}, 32'(pop_d0), 32'd0);
    chk({tag, "/pop_d1"}, 32'(pop_d1), 32'd0);
    chk({tag, "/valid"}, 32'(valid_out), 32'd0);
    chk({tag, "/data"}, 32'(data_out), 32'd0);
    chk({tag, "/src"}, 32'(src_id), 32'd0);
    chk({tag, "/err"}, 32'(rd_error), 32'd0);
  endtask

  // Advance one cycle, then compare every output against the hand-derived row.
  task automatic expc(input string tag, input bit p0, input bit p1, input bit v,
                      input logic [5:0] d, input bit s, input bit err);
    cyc();
    chk({tag, "/pop_d0"}, 32'(pop_d0), 32'(p0));
    chk({tag, "/pop_d1"}, 32'(pop_d1), 32'(p1));
    chk({tag, "/valid"}, 32'(valid_out), 32'(v));
    chk({tag, "/data"}, 32'(data_out), 32'(d));
    if (v) chk({tag, "/src"}, 32'(src_id), 32'(s));
    chk({tag, "/err"}, 32'(rd_error), 32'(err));
  endtask

  initial begin
    reset      = 1'b1;
    down_pause = 1'b0;
    inj0       = 1'b0;
    cyc();
    cyc();
    chk_zero("reset");

    // d0 holds two items, d1 empty: pops every other cycle, never back to back.
    push0(6'h11);
    push0(6'h22);
    reset = 1'b0;
    expc("s1c0", 0, 0, 0, 6'h00, 0, 0);
    expc("s1c1", 1, 0, 0, 6'h00, 0, 0);
    expc("s1c2", 0, 0, 0, 6'h00, 0, 0);
    expc("s1c3", 1, 0, 1, 6'h11, 0, 0);
    expc("s1c4", 0, 0, 0, 6'h11, 0, 0);
    expc("s1c5", 0, 0, 1, 6'h22, 0, 0);
    expc("s1c6", 0, 0, 0, 6'h22, 0, 0);

    // Both sources hold three items: d1 wins the tie, then strict alternation.
    push0(6'h01); push0(6'h02); push0(6'h03);
    push1(6'h31); push1(6'h32); push1(6'h33);
    expc("s2c1", 0, 1, 0, 6'h22, 0, 0);
    expc("s2c2", 1, 0, 0, 6'h22, 0, 0);
    expc("s2c3", 0, 1, 1, 6'h31, 1, 0);
    expc("s2c4", 1, 0, 1, 6'h01, 0, 0);
    expc("s2c5", 0, 1, 1, 6'h32, 1, 0);
    expc("s2c6", 1, 0, 1, 6'h02, 0, 0);
    expc("s2c7", 0, 0, 1, 6'h33, 1, 0);
    expc("s2c8", 0, 0, 1, 6'h03, 0, 0);
    expc("s2c9", 0, 0, 0, 6'h03, 0, 0);

    // Pause rises during a pop cycle: in-flight pair drains, no new pops.
    push0(6'h0A); push0(6'h0B); push0(6'h0C);
    push1(6'h1A); push1(6'h1B); push1(6'h1C);
    expc("s3c1", 0, 1, 0, 6'h03, 0, 0);
    expc("s3c2", 1, 0, 0, 6'h03, 0, 0);
    down_pause = 1'b1;
    expc("s3c3", 0, 0, 1, 6'h1A, 1, 0);
    expc("s3c4", 0, 0, 1, 6'h0A, 0, 0);
    expc("s3c5", 0, 0, 0, 6'h0A, 0, 0);
    expc("s3c6", 0, 0, 0, 6'h0A, 0, 0);
    expc("s3c7", 0, 0, 0, 6'h0A, 0, 0);
    down_pause = 1'b0;
    expc("s3c8", 0, 1, 0, 6'h0A, 0, 0);
    expc("s3c9", 1, 0, 0, 6'h0A, 0, 0);
    expc("s3c10", 0, 1, 1, 6'h1B, 1, 0);
    expc("s3c11", 1, 0, 1, 6'h0B, 0, 0);
    expc("s3c12", 0, 0, 1, 6'h1C, 1, 0);
    expc("s3c13", 0, 0, 1, 6'h0C, 0, 0);
    expc("s3c14", 0, 0, 0, 6'h0C, 0, 0);

    // Reset while an item is one cycle from valid_out: it must be dropped.
    push0(6'h2A);
    expc("s4c1", 1, 0, 0, 6'h0C, 0, 0);
    expc("s4c2", 0, 0, 0, 6'h0C, 0, 0);
    reset = 1'b1;
    #1;
    chk_zero("s4async");
    push1(6'h15);
    cyc();
    chk_zero("s4held");
    reset = 1'b0;
    expc("s4r0", 0, 0, 0, 6'h00, 0, 0);
    expc("s4r1", 0, 1, 0, 6'h00, 0, 0);
    expc("s4r2", 0, 0, 0, 6'h00, 0, 0);
    expc("s4r3", 0, 0, 1, 6'h15, 1, 0);
    expc("s4r4", 0, 0, 0, 6'h15, 0, 0);

    // Empty flag forced high during POP0: single-cycle rd_error, item still delivered.
    push0(6'h07);
    expc("s5c1", 1, 0, 0, 6'h15, 0, 0);
    inj0 = 1'b1;
    expc("s5c2", 0, 0, 0, 6'h15, 0, 1);
    inj0 = 1'b0;
    expc("s5c3", 0, 0, 1, 6'h07, 0, 0);
    expc("s5c4", 0, 0, 0, 6'h07, 0, 0);

`ifdef FIFO_RD_STATS_EN
    reset = 1'b1;
    cyc();
    chk("cnt_rst_d0", 32'(pop_cnt_d0), 32'd0);
    chk("cnt_rst_d1", 32'(pop_cnt_d1), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      push0(6'(i));
      push1(6'(i + 1));
    end
    for (int i = 0; i < 310; i++) cyc();
    chk("cnt300_d0", 32'(pop_cnt_d0), 32'd150);
    chk("cnt300_d1", 32'(pop_cnt_d1), 32'd150);
    for (int i = 0; i < 150; i++) begin
      push0(6'(i));
      push1(6'(i + 1));
    end
    for (int i = 0; i < 310; i++) cyc();
    chk("cnt600_d0", 32'(pop_cnt_d0), 32'd255);
    chk("cnt600_d1", 32'(pop_cnt_d1), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
